// File: rtl/fb_pixel_queue.sv
// fb_pixel_queue: framebuffer pixel address stage feeding a FWFT queue.
// Optional clipping of off-screen pixels: define FB_PIXEL_QUEUE_CLIP_EN.
module fb_pixel_queue #(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int          FB_WIDTH   = 640,
    parameter int          FB_HEIGHT  = 480,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                  PLB_clk,
    input  logic                  PLB_rst_n,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic [31:0]           pix_color,
    output logic [0:63]           fifo_data,
    output logic                  fifo_empty,
    input  logic                  fifo_rd_en,
`ifdef FB_PIXEL_QUEUE_CLIP_EN
    output logic [15:0]           clip_drops,
`endif
    output logic [DEPTH_LOG2:0]   fifo_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic                  stage_valid;
    logic [63:0]           stage_data;
    logic [63:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [63:0]           hold_q;
    logic [31:0]           lin;
    logic [31:0]           addr;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  take;

    // Linear pixel index and byte address, modulo 2**32
    always_comb begin
        lin  = 32'(pix_y) * 32'(FB_WIDTH) + 32'(pix_x);
        addr = FB_BASE + (lin << 2);
    end

    // Handshake and queue control, full taken from the registered count
    always_comb begin
        full      = (count == FULL_CNT);
        pix_ready = !stage_valid || !full;
        accept    = pix_valid && pix_ready;
        push      = stage_valid && !full;
        pop       = fifo_rd_en && (count != '0);
    end

`ifdef FB_PIXEL_QUEUE_CLIP_EN
    logic clipped;

    // Off-screen pixels complete the handshake but are discarded
    always_comb begin
        clipped = (32'(pix_x) >= 32'(FB_WIDTH)) ||
                  (32'(pix_y) >= 32'(FB_HEIGHT));
        take    = accept && !clipped;
    end

    // Saturating count of discarded pixels
    always_ff @(posedge PLB_clk or negedge PLB_rst_n) begin
        if (!PLB_rst_n) begin
            clip_drops <= '0;
        end else if (accept && clipped && clip_drops != 16'hFFFF) begin
            clip_drops <= clip_drops + 16'd1;
        end
    end
`else
    // Every accepted pixel is staged
    always_comb take = accept;
`endif

    // Stage register: refills in the same cycle its entry moves on
    always_ff @(posedge PLB_clk or negedge PLB_rst_n) begin
        if (!PLB_rst_n) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (take) begin
            stage_valid <= 1'b1;
            stage_data  <= {addr, pix_color};
        end else if (push) begin
            stage_valid <= 1'b0;
        end
    end

    // Queue storage, contents survive reset
    always_ff @(posedge PLB_clk) begin
        if (push) mem[wr_ptr] <= stage_data;
    end

    // Pointers and occupancy
    always_ff @(posedge PLB_clk or negedge PLB_rst_n) begin
        if (!PLB_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Last popped head, presented while the queue is empty
    always_ff @(posedge PLB_clk or negedge PLB_rst_n) begin
        if (!PLB_rst_n) begin
            hold_q <= '0;
        end else if (pop) begin
            hold_q <= mem[rd_ptr];
        end
    end

    // First-word-fall-through head
    always_comb begin
        fifo_empty = (count == '0);
        fifo_count = count;
        fifo_data  = fifo_empty ? hold_q : mem[rd_ptr];
    end

endmodule
